// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_stage_if : instruction-memory request/ready bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_stage : MIPS IF stage - PC register, imem handshake, IF/ID register
// Optional IF_MISALIGN_CHECK_EN adds the sticky if_adel misaligned-fetch flag.
// Rev 1.0
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [31:0]       NPC,
   input  logic              stall,
   input  logic              flush,
   if_fetch_stage_if.master  imem,
   output logic [31:0]       PC,
   output logic [31:0]       ID_PC,
   output logic [31:0]       ID_Instr,
`ifdef IF_MISALIGN_CHECK_EN
   output logic              if_adel,
`endif
   output logic              ID_valid
);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t      r_state, w_state_nx;
   logic        r_req_en;
   logic [31:0] r_pc, w_pc_nx;
   logic [31:0] r_id_pc, w_id_pc_nx;
   logic [31:0] r_id_instr, w_id_instr_nx;
   logic        r_id_valid, w_id_valid_nx;
   logic [31:0] r_skid_pc, w_skid_pc_nx;
   logic [31:0] r_skid_instr, w_skid_instr_nx;
   logic        w_req;
   logic        w_fire;

`ifdef IF_MISALIGN_CHECK_EN
   logic        r_adel, w_adel_nx;
   logic        w_misalign;

   assign w_misalign = (r_pc[1:0] != 2'b00);
   assign w_req      = r_req_en && (r_state == S_FETCH) && !w_misalign;
   assign if_adel    = r_adel;
`else
   // r_req_en keeps the request low for the first cycle after a reset edge
   assign w_req      = r_req_en && (r_state == S_FETCH);
`endif

   assign w_fire          = w_req && imem.imem_ready;
   assign imem.imem_req   = w_req;
   assign imem.imem_addr  = r_pc;
   assign PC              = r_pc;
   assign ID_PC           = r_id_pc;
   assign ID_Instr        = r_id_instr;
   assign ID_valid        = r_id_valid;

   always_comb begin
      w_state_nx      = r_state;
      w_pc_nx         = r_pc;
      w_id_pc_nx      = r_id_pc;
      w_id_instr_nx   = r_id_instr;
      w_id_valid_nx   = r_id_valid;
      w_skid_pc_nx    = r_skid_pc;
      w_skid_instr_nx = r_skid_instr;
`ifdef IF_MISALIGN_CHECK_EN
      w_adel_nx       = r_adel;
`endif
      if (flush) begin
         w_id_instr_nx = NOP_INSTR;
         w_id_valid_nx = 1'b0;
         w_state_nx    = S_FETCH;
         if (w_fire) begin
            w_pc_nx = NPC;
         end
`ifdef IF_MISALIGN_CHECK_EN
         w_adel_nx = 1'b0;
         if (w_misalign && (r_state == S_FETCH)) begin
            w_pc_nx = NPC;
         end
`endif
      end else if (r_state == S_HOLD) begin
         if (!stall) begin
            w_id_pc_nx    = r_skid_pc;
            w_id_instr_nx = r_skid_instr;
            w_id_valid_nx = 1'b1;
            w_state_nx    = S_FETCH;
         end
      end else if (w_fire) begin
         w_pc_nx = NPC;
         if (stall) begin
            // park the returned word so PC can move on while decode is held
            w_skid_pc_nx    = r_pc;
            w_skid_instr_nx = imem.imem_rdata;
            w_state_nx      = S_HOLD;
         end else begin
            w_id_pc_nx    = r_pc;
            w_id_instr_nx = imem.imem_rdata;
            w_id_valid_nx = 1'b1;
         end
      end else if (!stall) begin
         w_id_pc_nx    = r_pc;
         w_id_instr_nx = NOP_INSTR;
         w_id_valid_nx = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
         if (w_misalign) begin
            w_adel_nx = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_FETCH;
         r_req_en     <= 1'b0;
         r_pc         <= RESET_PC;
         r_id_pc      <= 32'h0000_0000;
         r_id_instr   <= NOP_INSTR;
         r_id_valid   <= 1'b0;
         r_skid_pc    <= 32'h0000_0000;
         r_skid_instr <= NOP_INSTR;
`ifdef IF_MISALIGN_CHECK_EN
         r_adel       <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nx;
         r_req_en     <= 1'b1;
         r_pc         <= w_pc_nx;
         r_id_pc      <= w_id_pc_nx;
         r_id_instr   <= w_id_instr_nx;
         r_id_valid   <= w_id_valid_nx;
         r_skid_pc    <= w_skid_pc_nx;
         r_skid_instr <= w_skid_instr_nx;
`ifdef IF_MISALIGN_CHECK_EN
         r_adel       <= w_adel_nx;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_fetch_stage : scoreboard bench for if_fetch_stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   logic        clk;
   logic        rstn;
   logic        stall;
   logic        flush;
   logic [31:0] npc;
   logic [31:0] pc;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        npc_ovr_en;
   logic [31:0] npc_ovr;
`ifdef IF_MISALIGN_CHECK_EN
   logic        if_adel;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_entry_t;

   sb_entry_t sb[$];

   if_fetch_stage_if imem ();

   if_fetch_stage dut (
      .clk      (clk),
      .rstn     (rstn),
      .NPC      (npc),
      .stall    (stall),
      .flush    (flush),
      .imem     (imem.master),
      .PC       (pc),
      .ID_PC    (id_pc),
      .ID_Instr (id_instr),
`ifdef IF_MISALIGN_CHECK_EN
      .if_adel  (if_adel),
`endif
      .ID_valid (id_valid)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // npc block model: sequential PC+4 unless a branch target is forced
   assign npc             = npc_ovr_en ? npc_ovr : pc + 32'd4;
   assign imem.imem_rdata = mem_word(imem.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic rdy, input logic st, input logic fl);
      imem.imem_ready = rdy;
      stall           = st;
      flush           = fl;
      if (rstn && imem.imem_req && rdy && !fl) begin
         sb.push_back({imem.imem_addr, mem_word(imem.imem_addr)});
      end
      @(negedge clk);
   endtask

   // Each new valid IF/ID content is one DUT output
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc    = '0;
   logic [31:0] prev_instr = '0;
   always @(negedge clk) begin
      if (id_valid && (!prev_valid || id_pc != prev_pc || id_instr != prev_instr)) begin
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            sb_entry_t e;
            e = sb.pop_front();
            check_eq("sb_id_pc", id_pc, e.pc);
            check_eq("sb_id_instr", id_instr, e.instr);
         end
      end
      prev_valid = id_valid;
      prev_pc    = id_pc;
      prev_instr = id_instr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn            = 1'b0;
      stall           = 1'b0;
      flush           = 1'b0;
      imem.imem_ready = 1'b0;
      npc_ovr_en      = 1'b0;
      npc_ovr         = '0;
      @(negedge clk);
      @(negedge clk);

      check_eq("rst_pc",       pc, 32'h0000_3000);
      check_eq("rst_id_pc",    id_pc, 32'h0);
      check_eq("rst_id_instr", id_instr, 32'h0);
      check_eq("rst_id_valid", 32'(id_valid), 32'd0);
      check_eq("rst_req",      32'(imem.imem_req), 32'd0);
      check_eq("rst_addr",     imem.imem_addr, 32'h0000_3000);

      // Zero-wait streaming
      rstn = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      check_eq("first_req",  32'(imem.imem_req), 32'd1);
      check_eq("first_addr", imem.imem_addr, 32'h0000_3000);
      step(1'b1, 1'b0, 1'b0);
      check_eq("stream_addr1",  imem.imem_addr, 32'h0000_3004);
      check_eq("stream_valid1", 32'(id_valid), 32'd1);
      check_eq("stream_id_pc1", id_pc, 32'h0000_3000);

      // Wait states at 0x3004
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check_eq("wait_addr",  imem.imem_addr, 32'h0000_3004);
         check_eq("wait_req",   32'(imem.imem_req), 32'd1);
         check_eq("wait_valid", 32'(id_valid), 32'd0);
      end
      step(1'b1, 1'b0, 1'b0);
      check_eq("wait_done_pc",    pc, 32'h0000_3008);
      check_eq("wait_done_id_pc", id_pc, 32'h0000_3004);

      // Stall on completion at 0x3008, held two cycles
      step(1'b1, 1'b1, 1'b0);
      check_eq("hold_req1",   32'(imem.imem_req), 32'd0);
      check_eq("hold_id_pc1", id_pc, 32'h0000_3004);
      check_eq("hold_pc1",    pc, 32'h0000_300C);
      step(1'b1, 1'b1, 1'b0);
      check_eq("hold_req2",   32'(imem.imem_req), 32'd0);
      check_eq("hold_id_pc2", id_pc, 32'h0000_3004);
      check_eq("hold_pc2",    pc, 32'h0000_300C);
      step(1'b1, 1'b0, 1'b0);
      check_eq("unhold_id_pc", id_pc, 32'h0000_3008);
      check_eq("unhold_valid", 32'(id_valid), 32'd1);
      check_eq("unhold_addr",  imem.imem_addr, 32'h0000_300C);
      check_eq("unhold_req",   32'(imem.imem_req), 32'd1);

      // Flush on completion at 0x300C, redirect to 0x4000
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'h0000_4000;
      step(1'b1, 1'b0, 1'b1);
      npc_ovr_en = 1'b0;
      check_eq("flush_valid", 32'(id_valid), 32'd0);
      check_eq("flush_instr", id_instr, 32'h0);
      check_eq("flush_pc",    pc, 32'h0000_4000);
      step(1'b1, 1'b0, 1'b0);
      check_eq("redir_id_pc", id_pc, 32'h0000_4000);

      // PC wrap through 0xFFFF_FFFC
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'hFFFF_FFFC;
      step(1'b1, 1'b0, 1'b1);
      npc_ovr_en = 1'b0;
      check_eq("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0);
      check_eq("wrap_pc",    pc, 32'h0000_0000);
      check_eq("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

      // Reset asserted during a wait
      step(1'b0, 1'b0, 1'b0);
      check_eq("pre_rst_req", 32'(imem.imem_req), 32'd1);
      rstn = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      check_eq("mid_rst_pc",    pc, 32'h0000_3000);
      check_eq("mid_rst_req",   32'(imem.imem_req), 32'd0);
      check_eq("mid_rst_valid", 32'(id_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0);
      check_eq("late_ready_pc", pc, 32'h0000_3000);
      rstn = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      check_eq("restart_req",  32'(imem.imem_req), 32'd1);
      check_eq("restart_addr", imem.imem_addr, 32'h0000_3000);
      step(1'b1, 1'b0, 1'b0);
      check_eq("restart_id_pc", id_pc, 32'h0000_3000);

`ifdef IF_MISALIGN_CHECK_EN
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'h0000_3002;
      step(1'b1, 1'b0, 1'b0);
      npc_ovr_en = 1'b0;
      check_eq("mis_req", 32'(imem.imem_req), 32'd0);
      step(1'b1, 1'b0, 1'b0);
      check_eq("mis_adel",  32'(if_adel), 32'd1);
      check_eq("mis_valid", 32'(id_valid), 32'd0);
      check_eq("mis_id_pc", id_pc, 32'h0000_3002);
      step(1'b1, 1'b0, 1'b0);
      check_eq("mis_pc_hold", pc, 32'h0000_3002);
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'h0000_8000;
      step(1'b0, 1'b0, 1'b1);
      npc_ovr_en = 1'b0;
      check_eq("mis_adel_clr", 32'(if_adel), 32'd0);
      check_eq("mis_pc_redir", pc, 32'h0000_8000);
      step(1'b1, 1'b0, 1'b0);
      check_eq("mis_resume_id_pc", id_pc, 32'h0000_8000);
`endif

      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
